// File: rtl/issue_sched.sv
// Dual-issue scheduler for the decode pair: decides single/dual issue, parks the
// younger slot in a pending copy, and serialises TLB operations.
module issue_sched (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       stall,
  input  logic       flush,
  input  logic       exception_flush,
  input  logic       a_valid,
  input  logic       b_valid,
  input  logic [4:0] a_rs,
  input  logic [4:0] a_rt,
  input  logic [4:0] b_rs,
  input  logic [4:0] b_rt,
  input  logic       a_w_reg_ena,
  input  logic       b_w_reg_ena,
  input  logic [4:0] a_w_reg_dst,
  input  logic [4:0] b_w_reg_dst,
  input  logic       a_is_branch,
  input  logic       b_is_branch,
  input  logic       a_is_ls,
  input  logic       b_is_ls,
  input  logic       a_is_tlb,
  input  logic       b_is_tlb,
  output logic       issue0_valid,
  output logic       issue1_valid,
  output logic       pipe0_from_pend,
  output logic       pend_load,
  output logic       in_stall
);

  typedef enum logic [1:0] {NORM, HOLD, SERIAL} state_t;

  state_t     state, state_nxt;
  logic       pend_valid, pend_valid_nxt;
  logic [1:0] cnt, cnt_nxt;
  logic [4:0] pend_rs, pend_rt, pend_w_reg_dst;
  logic       pend_w_reg_ena, pend_is_tlb;
  logic       raw, dual, flush_now;

  assign raw = a_w_reg_ena && (a_w_reg_dst != '0) &&
               ((a_w_reg_dst == b_rs) || (a_w_reg_dst == b_rt));
  assign dual = a_valid && b_valid && !raw && !(a_is_ls && b_is_ls) &&
                !b_is_branch && !a_is_tlb && !b_is_tlb;
  assign flush_now = exception_flush || (flush && !stall);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= NORM;
      pend_valid     <= 1'b0;
      cnt            <= '0;
      pend_rs        <= '0;
      pend_rt        <= '0;
      pend_w_reg_ena <= 1'b0;
      pend_w_reg_dst <= '0;
      pend_is_tlb    <= 1'b0;
    end else begin
      state      <= state_nxt;
      pend_valid <= pend_valid_nxt;
      cnt        <= cnt_nxt;
      if (pend_load) begin
        pend_rs        <= b_rs;
        pend_rt        <= b_rt;
        pend_w_reg_ena <= b_w_reg_ena;
        pend_w_reg_dst <= b_w_reg_dst;
        pend_is_tlb    <= b_is_tlb;
      end
    end
  end

  always_comb begin
    state_nxt       = state;
    pend_valid_nxt  = pend_valid;
    cnt_nxt         = cnt;
    issue0_valid    = 1'b0;
    issue1_valid    = 1'b0;
    pipe0_from_pend = 1'b0;
    pend_load       = 1'b0;
    in_stall        = 1'b0;
    if (!rst_n) begin
      state_nxt = NORM;
    end else if (flush_now) begin
      state_nxt      = NORM;
      pend_valid_nxt = 1'b0;
      cnt_nxt        = '0;
    end else begin
      unique case (state)
        NORM: begin
          if (a_valid) begin
            issue0_valid = 1'b1;
            issue1_valid = dual;
            if (!dual) begin
              if (b_valid) begin
                pend_load      = 1'b1;
                pend_valid_nxt = 1'b1;
              end
              if (a_is_tlb) begin
                state_nxt = SERIAL;
                cnt_nxt   = 2'd3;
              end else if (b_valid) begin
                state_nxt = HOLD;
              end
            end
          end
        end
        HOLD: begin
          issue0_valid    = 1'b1;
          pipe0_from_pend = 1'b1;
          in_stall        = 1'b1;
          pend_valid_nxt  = 1'b0;
          if (pend_is_tlb) begin
            state_nxt = SERIAL;
            cnt_nxt   = 2'd3;
          end else begin
            state_nxt = NORM;
          end
        end
        SERIAL: begin
          in_stall = 1'b1;
          if (cnt != '0) cnt_nxt = cnt - 2'd1;
          if (cnt <= 2'd1) state_nxt = pend_valid ? HOLD : NORM;
        end
        default: state_nxt = NORM;
      endcase
      // A stall freezes every register but leaves the issue decision visible.
      if (stall) begin
        state_nxt      = state;
        pend_valid_nxt = pend_valid;
        cnt_nxt        = cnt;
        pend_load      = 1'b0;
        in_stall       = 1'b1;
      end
    end
  end

  logic unused_sigs;
  assign unused_sigs = ^{a_rs, a_rt, a_is_branch, pend_rs, pend_rt,
                         pend_w_reg_ena, pend_w_reg_dst};

endmodule

// File: tb/tb_issue_sched.sv
// Bench for issue_sched: directed scenarios plus randomized pairs checked
// against a work-queue model of the scheduler.
module tb_issue_sched;

  logic       clk = 1'b0;
  logic       rst_n, stall, flush, exception_flush;
  logic       a_valid, b_valid;
  logic [4:0] a_rs, a_rt, b_rs, b_rt, a_w_reg_dst, b_w_reg_dst;
  logic       a_w_reg_ena, b_w_reg_ena;
  logic       a_is_branch, b_is_branch, a_is_ls, b_is_ls, a_is_tlb, b_is_tlb;
  logic       issue0_valid, issue1_valid, pipe0_from_pend, pend_load, in_stall;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  // Model: queue of cycles the scheduler still owes ("S" = serial bubble,
  // "P" = issue pending B); empty queue means a fresh pair is examined.
  byte  work_q[$];
  logic m_pend_tlb;

  always #5 clk = ~clk;

  issue_sched dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .exception_flush(exception_flush),
    .a_valid(a_valid), .b_valid(b_valid),
    .a_rs(a_rs), .a_rt(a_rt), .b_rs(b_rs), .b_rt(b_rt),
    .a_w_reg_ena(a_w_reg_ena), .b_w_reg_ena(b_w_reg_ena),
    .a_w_reg_dst(a_w_reg_dst), .b_w_reg_dst(b_w_reg_dst),
    .a_is_branch(a_is_branch), .b_is_branch(b_is_branch),
    .a_is_ls(a_is_ls), .b_is_ls(b_is_ls),
    .a_is_tlb(a_is_tlb), .b_is_tlb(b_is_tlb),
    .issue0_valid(issue0_valid), .issue1_valid(issue1_valid),
    .pipe0_from_pend(pipe0_from_pend), .pend_load(pend_load),
    .in_stall(in_stall)
  );

  function automatic logic [4:0] dut_out();
    return {issue0_valid, issue1_valid, pipe0_from_pend, pend_load, in_stall};
  endfunction

  function automatic logic pair_dual();
    logic raw;
    raw = a_w_reg_ena && a_w_reg_dst != 0 && (a_w_reg_dst == b_rs || a_w_reg_dst == b_rt);
    return a_valid && b_valid && !raw && !(a_is_ls && b_is_ls) && !b_is_branch &&
           !a_is_tlb && !b_is_tlb;
  endfunction

  // Expected {issue0, issue1, from_pend, pend_load, in_stall}.
  function automatic logic [4:0] model_out();
    logic d;
    if (!rst_n) return 5'b00000;
    if (exception_flush || (flush && !stall)) return 5'b00000;
    if (work_q.size() != 0) return (work_q[0] == "S") ? 5'b00001 : 5'b10101;
    if (!a_valid) return {4'b0000, stall};
    d = pair_dual();
    return {1'b1, d, 1'b0, !d && b_valid && !stall, stall};
  endfunction

  task automatic model_step();
    byte w;
    if (!rst_n || exception_flush || (flush && !stall)) begin
      work_q.delete();
    end else if (!stall) begin
      if (work_q.size() != 0) begin
        w = work_q.pop_front();
        if (w == "P" && m_pend_tlb) repeat (3) work_q.push_back("S");
      end else if (a_valid && !pair_dual()) begin
        if (a_is_tlb) repeat (3) work_q.push_back("S");
        if (b_valid) begin
          work_q.push_back("P");
          m_pend_tlb = b_is_tlb;
        end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    stall = 0; flush = 0; exception_flush = 0;
    a_valid = 0; b_valid = 0;
    a_rs = 5'd1; a_rt = 5'd2; b_rs = 5'd5; b_rt = 5'd6;
    a_w_reg_ena = 0; b_w_reg_ena = 0; a_w_reg_dst = 0; b_w_reg_dst = 0;
    a_is_branch = 0; b_is_branch = 0; a_is_ls = 0; b_is_ls = 0;
    a_is_tlb = 0; b_is_tlb = 0;
  endtask

  task automatic raw_pair();
    clear_in();
    a_valid = 1; b_valid = 1;
    a_w_reg_ena = 1; a_w_reg_dst = 5'd7; b_rs = 5'd7;
  endtask

  task automatic tlb_pair();
    clear_in();
    a_valid = 1; b_valid = 1; a_is_tlb = 1;
  endtask

  task automatic test_reset();
    clear_in();
    a_valid = 1; b_valid = 1;
    rst_n = 0;
    work_q.delete();
    #3;
    n_total++;
    if (dut_out() !== 5'b00000) $display("FAIL reset_outputs got %b exp 00000", dut_out());
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (dut_out() !== model_out()) $display("FAIL reset_model got %b exp %b", dut_out(), model_out());
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1;
    clear_in();
    @(negedge clk);
    n_total++;
    if (dut_out() !== 5'b00000) $display("FAIL reset_idle got %b exp 00000", dut_out());
    else n_pass++;
    tick();
  endtask

  task automatic test_dual();
    clear_in();
    a_valid = 1; b_valid = 1; a_w_reg_ena = 1; a_w_reg_dst = 5'd3;
    b_w_reg_ena = 1; b_w_reg_dst = 5'd4; b_rs = 5'd5;
    @(negedge clk);
    n_total++;
    if (dut_out() !== 5'b11000) $display("FAIL dual_add got %b exp 11000", dut_out());
    else n_pass++;
    tick();
    clear_in();
    a_valid = 1; b_valid = 1; a_w_reg_ena = 1; a_w_reg_dst = 5'd0; b_rs = 5'd0;
    @(negedge clk);
    n_total++;
    if (dut_out() !== 5'b11000) $display("FAIL dual_r0 got %b exp 11000", dut_out());
    else n_pass++;
    tick();
    clear_in();
    @(negedge clk);
    n_total++;
    if (dut_out() !== 5'b00000) $display("FAIL dual_stays_norm got %b exp 00000", dut_out());
    else n_pass++;
    tick();
  endtask

  task automatic test_raw_hold();
    raw_pair();
    @(negedge clk);
    n_total++;
    if (dut_out() !== 5'b10010) $display("FAIL raw_cycle0 got %b exp 10010", dut_out());
    else n_pass++;
    tick();
    clear_in();
    @(negedge clk);
    n_total++;
    if (dut_out() !== 5'b10101) $display("FAIL raw_hold got %b exp 10101", dut_out());
    else n_pass++;
    tick();
    @(negedge clk);
    n_total++;
    if (dut_out() !== 5'b00000) $display("FAIL raw_back_norm got %b exp 00000", dut_out());
    else n_pass++;
    tick();
  endtask

  task automatic test_tlb_serial();
    tlb_pair();
    @(negedge clk);
    n_total++;
    if (dut_out() !== 5'b10010) $display("FAIL tlb_issue_a got %b exp 10010", dut_out());
    else n_pass++;
    tick();
    clear_in();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_total++;
      if (dut_out() !== 5'b00001) $display("FAIL tlb_serial%0d got %b exp 00001", i, dut_out());
      else n_pass++;
      tick();
    end
    @(negedge clk);
    n_total++;
    if (dut_out() !== 5'b10101) $display("FAIL tlb_hold_b got %b exp 10101", dut_out());
    else n_pass++;
    tick();
    @(negedge clk);
    n_total++;
    if (dut_out() !== 5'b00000) $display("FAIL tlb_back_norm got %b exp 00000", dut_out());
    else n_pass++;
    tick();
  endtask

  task automatic test_hold_stall();
    raw_pair();
    tick();
    clear_in();
    stall = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_total++;
      if (dut_out() !== 5'b10101) $display("FAIL hold_stall%0d got %b exp 10101", i, dut_out());
      else n_pass++;
      tick();
    end
    stall = 0;
    @(negedge clk);
    n_total++;
    if (dut_out() !== 5'b10101) $display("FAIL hold_release got %b exp 10101", dut_out());
    else n_pass++;
    tick();
    @(negedge clk);
    n_total++;
    if (dut_out() !== 5'b00000) $display("FAIL hold_done got %b exp 00000", dut_out());
    else n_pass++;
    tick();
  endtask

  task automatic test_exc_flush();
    tlb_pair();
    tick();
    clear_in();
    tick();
    stall = 1; exception_flush = 1;
    @(negedge clk);
    n_total++;
    if (dut_out() !== 5'b00000) $display("FAIL exc_flush_now got %b exp 00000", dut_out());
    else n_pass++;
    tick();
    clear_in();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_total++;
      if (dut_out() !== 5'b00000) $display("FAIL exc_flush_after%0d got %b exp 00000", i, dut_out());
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_flush_stall();
    raw_pair();
    tick();
    clear_in();
    stall = 1; flush = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_total++;
      if (dut_out() !== 5'b10101) $display("FAIL flush_stalled%0d got %b exp 10101", i, dut_out());
      else n_pass++;
      tick();
    end
    stall = 0;
    @(negedge clk);
    n_total++;
    if (dut_out() !== 5'b00000) $display("FAIL flush_applied got %b exp 00000", dut_out());
    else n_pass++;
    tick();
    clear_in();
    @(negedge clk);
    n_total++;
    if (dut_out() !== 5'b00000) $display("FAIL flush_norm got %b exp 00000", dut_out());
    else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid();
    tlb_pair();
    tick();
    clear_in();
    #2;
    rst_n = 0;
    #1;
    work_q.delete();
    n_total++;
    if (dut_out() !== 5'b00000) $display("FAIL midreset_outputs got %b exp 00000", dut_out());
    else n_pass++;
    @(posedge clk); #2;
    rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_total++;
      if (dut_out() !== 5'b00000) $display("FAIL midreset_discard%0d got %b exp 00000", i, dut_out());
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      a_valid = $urandom_range(0, 3) != 0;
      b_valid = $urandom_range(0, 3) != 0;
      a_rs = 5'($urandom_range(0, 3)); a_rt = 5'($urandom_range(0, 3));
      b_rs = 5'($urandom_range(0, 3)); b_rt = 5'($urandom_range(0, 3));
      a_w_reg_ena = $urandom_range(0, 1) == 1;
      b_w_reg_ena = $urandom_range(0, 1) == 1;
      a_w_reg_dst = 5'($urandom_range(0, 3)); b_w_reg_dst = 5'($urandom_range(0, 3));
      a_is_branch = $urandom_range(0, 4) == 0; b_is_branch = $urandom_range(0, 4) == 0;
      a_is_ls = $urandom_range(0, 2) == 0; b_is_ls = $urandom_range(0, 2) == 0;
      a_is_tlb = $urandom_range(0, 9) == 0; b_is_tlb = $urandom_range(0, 9) == 0;
      stall = $urandom_range(0, 3) == 0;
      flush = $urandom_range(0, 15) == 0;
      exception_flush = $urandom_range(0, 31) == 0;
      @(negedge clk);
      n_total++;
      if (dut_out() !== model_out())
        $display("FAIL random_cycle%0d got %b exp %b", i, dut_out(), model_out());
      else n_pass++;
      tick();
    end
  endtask

  initial begin
    m_pend_tlb = 0;
    clear_in();
    rst_n = 1;
    #1;
    test_reset();
    test_dual();
    test_raw_hold();
    test_tlb_serial();
    test_hold_stall();
    test_exc_flush();
    test_flush_stall();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
